// File: rtl/rt_output_arbiter.sv
// Round-robin arbiter funnelling NUM_IN four-phase req/ack inputs onto one
// four-phase output port; payload is captured once per grant and held until the return handshake.
module rt_output_arbiter #(
  parameter int WIDTH  = 512,
  parameter int NUM_IN = 4,
  parameter int IDW    = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN-1:0]       in_req,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ack,
  output logic                    out_req,
  output logic [WIDTH-1:0]        out_data,
  input  logic                    out_ack,
  output logic [IDW-1:0]          grant_id,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    RET  = 2'd2
  } state_t;

  state_t           state_r;
  logic [IDW-1:0]   ptr_r;
  logic [IDW-1:0]   grant_s;
  logic [IDW-1:0]   cand_s;
  logic             found_s;
  logic [IDW-1:0]   ptr_next_s;
  logic [NUM_IN-1:0] ack_onehot_s;

  // Rotating priority search: first requester at or above ptr, wrapping past NUM_IN-1.
  always_comb begin
    grant_s = ptr_r;
    cand_s  = ptr_r;
    found_s = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if ((int'(ptr_r) + k) >= NUM_IN) begin
        cand_s = IDW'(int'(ptr_r) + k - NUM_IN);
      end else begin
        cand_s = IDW'(int'(ptr_r) + k);
      end
      if (!found_s && in_req[cand_s]) begin
        grant_s = cand_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer advance and acknowledge decode for the currently granted input.
  always_comb begin
    if (grant_id == IDW'(NUM_IN - 1)) begin
      ptr_next_s = {IDW{1'b0}};
    end else begin
      ptr_next_s = grant_id + IDW'(1);
    end
    ack_onehot_s = {{(NUM_IN-1){1'b0}}, 1'b1} << grant_id;
  end

  // Handshake FSM; all outputs are registered so they move only with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      ptr_r    <= {IDW{1'b0}};
      in_ack   <= {NUM_IN{1'b0}};
      out_req  <= 1'b0;
      out_data <= {WIDTH{1'b0}};
      grant_id <= {IDW{1'b0}};
      busy     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|in_req) begin
            state_r  <= FWD;
            out_req  <= 1'b1;
            out_data <= in_data[grant_s*WIDTH +: WIDTH];
            grant_id <= grant_s;
            busy     <= 1'b1;
          end
        end
        FWD: begin
          // A requester dropping early is ignored: the forwarded transfer still completes.
          if (out_ack) begin
            state_r <= RET;
            out_req <= 1'b0;
            in_ack  <= ack_onehot_s;
          end
        end
        RET: begin
          if (!in_req[grant_id] && !out_ack) begin
            state_r <= IDLE;
            in_ack  <= {NUM_IN{1'b0}};
            ptr_r   <= ptr_next_s;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          in_ack  <= {NUM_IN{1'b0}};
          out_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rt_output_arbiter.sv
// Directed bench for rt_output_arbiter: handshakes, round-robin order, wrap, busy, stall and reset.
module tb_rt_output_arbiter;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int ID = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   in_req;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ack;
  logic           out_req;
  logic [W-1:0]   out_data;
  logic           out_ack;
  logic [ID-1:0]  grant_id;
  logic           busy;
  logic [W-1:0]   dat [N];

  int vec_cnt = 0;
  int err_cnt = 0;

  assign in_data = {dat[3], dat[2], dat[1], dat[0]};

  rt_output_arbiter #(.WIDTH(W), .NUM_IN(N), .IDW(ID)) dut (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
    .out_req(out_req), .out_data(out_data), .out_ack(out_ack),
    .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full handshake from IDLE with a request already pending.
  task automatic xfer(input int g, input bit reraise, input logic [W-1:0] expd);
    tick();
    chk("grant_id", 32'(grant_id), 32'(g));
    chk("out_req_fwd", 32'(out_req), 32'd1);
    chk("out_data", 32'(out_data), 32'(expd));
    chk("busy_fwd", 32'(busy), 32'd1);
    out_ack = 1'b1;
    tick();
    chk("in_ack_ret", 32'(in_ack), 32'(4'b0001 << g));
    chk("out_req_ret", 32'(out_req), 32'd0);
    in_req[g] = 1'b0;
    out_ack   = 1'b0;
    tick();
    chk("in_ack_idle", 32'(in_ack), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    if (reraise) in_req[g] = 1'b1;
  endtask

  initial begin
    dat[0] = 16'h1100; dat[1] = 16'h2211; dat[2] = 16'h00A5; dat[3] = 16'h4433;
    rst_n = 1'b1; in_req = 4'b0000; out_ack = 1'b0;
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_out_req", 32'(out_req), 32'd0);
    chk("rst_in_ack", 32'(in_ack), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_req", 32'(busy), 32'd0);

    // Single transfer from input 2; ptr becomes 3.
    in_req = 4'b0100;
    xfer(2, 1'b0, 16'h00A5);

    // Wrap-around: ptr=3, requests on 0 and 1.
    in_req = 4'b0011;
    xfer(0, 1'b0, 16'h1100);
    xfer(1, 1'b0, 16'h2211);

    // ptr=2: input 3 alone moves ptr to 0.
    in_req = 4'b1000;
    xfer(3, 1'b0, 16'h4433);

    // Fairness with all requests held (re-raised after each return handshake).
    in_req = 4'b1111;
    xfer(0, 1'b1, 16'h1100);
    xfer(1, 1'b1, 16'h2211);
    xfer(2, 1'b1, 16'h00A5);
    xfer(3, 1'b1, 16'h4433);
    xfer(0, 1'b0, 16'h1100);
    in_req = 4'b0000;

    // Request while busy plus stalled downstream; ptr=1 so input 0 wins by wrapping.
    in_req = 4'b0001;
    tick();
    chk("busy_grant", 32'(grant_id), 32'd0);
    chk("busy_data", 32'(out_data), 32'h1100);
    in_req[1] = 1'b1;
    dat[0] = 16'hDEAD;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("stall_out_req", 32'(out_req), 32'd1);
      chk("stall_out_data", 32'(out_data), 32'h1100);
      chk("stall_in_ack", 32'(in_ack), 32'd0);
    end
    chk("stall_grant", 32'(grant_id), 32'd0);
    out_ack = 1'b1;
    tick();
    chk("busy_ack_only0", 32'(in_ack), 32'b0001);
    in_req[0] = 1'b0;
    out_ack   = 1'b0;
    tick();
    chk("busy_release", 32'(busy), 32'd0);
    dat[0] = 16'h1100;
    xfer(1, 1'b0, 16'h2211);
    in_req = 4'b0000;

    // Reset in RET: ptr=2 so input 3 is granted, then reset asynchronously.
    in_req = 4'b1010;
    tick();
    chk("pre_rst_grant", 32'(grant_id), 32'd3);
    out_ack = 1'b1;
    tick();
    chk("pre_rst_ack", 32'(in_ack), 32'b1000);
    #2 rst_n = 1'b0;
    #1;
    chk("async_in_ack", 32'(in_ack), 32'd0);
    chk("async_out_req", 32'(out_req), 32'd0);
    chk("async_out_data", 32'(out_data), 32'd0);
    chk("async_grant_id", 32'(grant_id), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    out_ack = 1'b0;
    tick();
    chk("rst_hold_ack", 32'(in_ack), 32'd0);
    rst_n = 1'b1;
    xfer(1, 1'b0, 16'h2211);
    in_req = 4'b0000;
    tick();
    chk("final_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/rt_output_arbiter.md
RT_OUTPUT_ARBITER -- requirements
Module: rt_output_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 512, meaning the payload width in bits of every port.
REQ-002 The block SHALL have parameter NUM_IN, default 4, meaning the number of requesting input ports (2..8).
REQ-003 The block SHALL have parameter IDW, default $clog2(NUM_IN), meaning the width of grant_id.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all logic SHALL be on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, meaning the reset, which is asynchronous and active-low.
REQ-006 The block SHALL have port in_req, input, NUM_IN, meaning per-input request with data valid.
REQ-007 The block SHALL have port in_data, input, NUM_IN*WIDTH, meaning the input payloads; input i occupies bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port in_ack, output, NUM_IN, meaning per-input acknowledge, registered.
REQ-009 The block SHALL have port out_req, output, 1, meaning the shared output request, registered.
REQ-010 The block SHALL have port out_data, output, WIDTH, meaning the registered payload of the granted input.
REQ-011 The block SHALL have port out_ack, input, 1, meaning the acknowledge from the downstream port.
REQ-012 The block SHALL have port grant_id, output, IDW, meaning the index of the current or last granted input.
REQ-013 The block SHALL have port busy, output, 1, meaning high whenever the state is not IDLE.

Function
REQ-014 All ports SHALL use a four-phase req/ack protocol: req rises with stable data, ack rises, req falls, ack falls; in_req and out_ack SHALL be synchronous to clk.
REQ-015 The FSM SHALL have exactly three states: IDLE, FWD and RET.
REQ-016 In IDLE, at an edge with any in_req bit high, the block SHALL grant index g and move to FWD; on that same edge it SHALL set out_req=1, out_data=in_data[g] and grant_id=g.
REQ-017 The grant index g SHALL be the first set in_req bit found searching upward from ptr, wrapping from NUM_IN-1 to 0.
REQ-018 In FWD, at an edge with out_ack=1, the block SHALL move to RET, set out_req=0 and set in_ack[g]=1.
REQ-019 In FWD with out_ack=0, the block SHALL hold all outputs; there is no timeout.
REQ-020 In RET, at an edge with in_req[g]=0 and out_ack=0, the block SHALL move to IDLE, set in_ack[g]=0 and set ptr=(g+1) mod NUM_IN.
REQ-021 In RET, the block SHALL remain in RET while either in_req[g] or out_ack is high.
REQ-022 At most one in_ack bit SHALL be high at any time, and only in RET.
REQ-023 out_data SHALL change only on the IDLE->FWD edge and SHALL be stable while out_req is high.
REQ-024 Requests arriving while busy=1 SHALL be ignored until IDLE; IDLE SHALL last at least one cycle between transfers.
REQ-025 If in_req[g] falls during FWD (protocol violation), the transfer SHALL complete unchanged.
REQ-026 Latency from an in_req sampled in IDLE to out_req high SHALL be 1 cycle; from out_ack sampled high to in_ack high SHALL be 1 cycle.
REQ-027 ptr SHALL be log2-sized and SHALL wrap modulo NUM_IN, including for non-power-of-two NUM_IN.

Reset
REQ-028 While rst_n=0, the block SHALL immediately force state=IDLE, ptr=0, in_ack=0, out_req=0, out_data=0, grant_id=0 and busy=0.
REQ-029 On reset assertion mid-transfer, the block SHALL abandon the transfer with no in_ack pulse; after deassertion, arbitration SHALL restart from ptr=0.

Verification
REQ-030 The bench SHALL cover a single transfer: NUM_IN=4, in_req[2]=1, data 0xA5 -> 1 cycle later out_req=1, out_data=0xA5, grant_id=2; out_ack=1 -> in_ack[2]=1 next cycle; drop in_req and out_ack -> in_ack=0, busy=0.
REQ-031 The bench SHALL cover round-robin fairness: all four in_req held continuously -> grants 0,1,2,3,0 in order.
REQ-032 The bench SHALL cover wrap-around: ptr=3 with in_req=0b0011 -> grant 0, then grant 1.
REQ-033 The bench SHALL cover a request while busy: in_req[1] raised during FWD of input 0 -> no in_ack[1] and out_data unchanged until input 0 completes; input 1 granted afterwards.
REQ-034 The bench SHALL cover a stalled downstream: out_ack held 0 for 100 cycles -> out_req stays 1 and out_data stays stable.
REQ-035 The bench SHALL cover reset mid-operation: rst_n pulsed low in RET -> all outputs 0 asynchronously, and the next grant after reset is the lowest requesting index.
